// File: rtl/morse_receiver.sv
`default_nettype none
// ============================================================================
// morse_receiver: tick-timed Morse line decoder emitting A-Z letter codes
// Revision: 1.0
// ============================================================================
module morse_receiver #(
  parameter int DASH_MIN   = 2,
  parameter int GAP_LETTER = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  output logic       valid,
  output logic [4:0] letter,
  output logic       err,
  output logic [3:0] pattern,
  output logic [2:0] length,
  output logic       busy
);

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_DASH    = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] C_GAP_END = CNT_W'(GAP_LETTER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Returns {err, letter}; symbol i sits in pat[i], 1 = dash.
  function automatic logic [5:0] decode(input logic [2:0] len, input logic [3:0] pat,
                                        input logic ovf);
    logic [5:0] r;
    r = {1'b1, 5'd31};
    if (!ovf) begin
      case (len)
        3'd1: r = pat[0] ? {1'b0, 5'd19} : {1'b0, 5'd4};
        3'd2: begin
          case (pat[1:0])
            2'b00:   r = {1'b0, 5'd8};
            2'b10:   r = {1'b0, 5'd0};
            2'b01:   r = {1'b0, 5'd13};
            default: r = {1'b0, 5'd12};
          endcase
        end
        3'd3: begin
          case (pat[2:0])
            3'b000:  r = {1'b0, 5'd18};
            3'b100:  r = {1'b0, 5'd20};
            3'b010:  r = {1'b0, 5'd17};
            3'b110:  r = {1'b0, 5'd22};
            3'b001:  r = {1'b0, 5'd3};
            3'b101:  r = {1'b0, 5'd10};
            3'b011:  r = {1'b0, 5'd6};
            default: r = {1'b0, 5'd14};
          endcase
        end
        3'd4: begin
          case (pat)
            4'b0000: r = {1'b0, 5'd7};
            4'b1000: r = {1'b0, 5'd21};
            4'b0100: r = {1'b0, 5'd5};
            4'b0010: r = {1'b0, 5'd11};
            4'b0110: r = {1'b0, 5'd15};
            4'b1110: r = {1'b0, 5'd9};
            4'b0001: r = {1'b0, 5'd1};
            4'b1001: r = {1'b0, 5'd23};
            4'b0101: r = {1'b0, 5'd2};
            4'b1101: r = {1'b0, 5'd24};
            4'b0011: r = {1'b0, 5'd25};
            4'b1011: r = {1'b0, 5'd16};
            default: r = {1'b1, 5'd31};
          endcase
        end
        default: r = {1'b1, 5'd31};
      endcase
    end
    return r;
  endfunction

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic [3:0]         buf_q,      buf_d;
  logic [2:0]         cnt_q,      cnt_d;
  logic               ovf_q,      ovf_d;
  logic               valid_q,    valid_d;
  logic [4:0]         letter_q,   letter_d;
  logic               err_q,      err_d;
  logic [3:0]         pattern_q,  pattern_d;
  logic [2:0]         length_q,   length_d;
  logic [CNT_W-1:0]   gap_next;
  logic [5:0]         dec;

  assign dec = decode(cnt_q, buf_q, ovf_q);

  always_comb begin
    state_d    = state_q;
    mark_cnt_d = mark_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    letter_d   = letter_q;
    err_d      = err_q;
    pattern_d  = pattern_q;
    length_d   = length_q;
    gap_next   = (gap_cnt_q == C_MAX) ? gap_cnt_q : gap_cnt_q + C_ONE;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (key) begin
            state_d    = ST_MARK;
            mark_cnt_d = C_ONE;
            buf_d      = 4'd0;
            cnt_d      = 3'd0;
            ovf_d      = 1'b0;
          end
        end
        ST_MARK: begin
          if (key) begin
            if (mark_cnt_q != C_MAX) mark_cnt_d = mark_cnt_q + C_ONE;
          end else begin
            // Fifth and later symbols only flag overflow; the first four are kept.
            if (cnt_q < 3'd4) begin
              buf_d[cnt_q[1:0]] = (mark_cnt_q >= C_DASH);
              cnt_d             = cnt_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d   = ST_GAP;
            gap_cnt_d = C_ONE;
          end
        end
        ST_GAP: begin
          if (key) begin
            state_d    = ST_MARK;
            mark_cnt_d = C_ONE;
          end else begin
            gap_cnt_d = gap_next;
            if (gap_next == C_GAP_END) begin
              state_d   = ST_IDLE;
              valid_d   = 1'b1;
              err_d     = dec[5];
              letter_d  = dec[4:0];
              pattern_d = buf_q;
              length_d  = cnt_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mark_cnt_q <= '0;
      gap_cnt_q  <= '0;
      buf_q      <= 4'd0;
      cnt_q      <= 3'd0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      letter_q   <= 5'd0;
      err_q      <= 1'b0;
      pattern_q  <= 4'd0;
      length_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      mark_cnt_q <= mark_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      letter_q   <= letter_d;
      err_q      <= err_d;
      pattern_q  <= pattern_d;
      length_q   <= length_d;
    end
  end

  assign valid   = valid_q;
  assign letter  = letter_q;
  assign err     = err_q;
  assign pattern = pattern_q;
  assign length  = length_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_receiver.sv
`default_nettype none
// ============================================================================
// tb_morse_receiver: directed self-checking bench for morse_receiver
// Revision: 1.0
// ============================================================================
module tb_morse_receiver;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       key;
  logic       valid;
  logic [4:0] letter;
  logic       err;
  logic [3:0] pattern;
  logic [2:0] length;
  logic       busy;

  int checks;
  int errors;
  int n_valid;

  morse_receiver #(
    .DASH_MIN  (2),
    .GAP_LETTER(3),
    .CNT_W     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .key    (key),
    .valid  (valid),
    .letter (letter),
    .err    (err),
    .pattern(pattern),
    .length (length),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) n_valid++;
  end

  // One Morse unit: a tick cycle, then two non-tick cycles with the key flipped.
  task automatic unit(input logic k);
    key  = k;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    key  = ~k;
    @(negedge clk);
    @(negedge clk);
    key  = k;
  endtask

  // Dots are 1 unit, dashes 3 units, 1-unit intra-letter spaces, 3-unit letter gap.
  task automatic send_letter(input logic [7:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      repeat (pat[i] ? 3 : 1) unit(1'b1);
      if (i < len - 1) unit(1'b0);
    end
    repeat (3) unit(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick  = 1'b0;
    key   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, letter, err, pattern, length, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", {valid, letter, err, pattern, length, busy});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_a;
    int v0;
    v0 = n_valid;
    unit(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL a_busy_mark got=%b want=1", busy);
    end
    unit(1'b0); unit(1'b1); unit(1'b1); unit(1'b0); unit(1'b0);
    checks++;
    if (n_valid !== v0) begin
      errors++;
      $display("FAIL a_early_valid got=%0d want=%0d", n_valid, v0);
    end
    key  = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL a_valid_timing got=%b want=1", valid);
    end
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd0, 4'b0010, 3'd2}) begin
      errors++;
      $display("FAIL a_outputs got err=%b letter=%0d pattern=%b length=%0d want 0 0 0010 2",
               err, letter, pattern, length);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || n_valid !== v0 + 1) begin
      errors++;
      $display("FAIL a_after valid=%b busy=%b pulses=%0d want 0 0 %0d", valid, busy, n_valid - v0, 1);
    end
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd0, 4'b0010, 3'd2}) begin
      errors++;
      $display("FAIL a_hold got letter=%0d pattern=%b length=%0d want 0 0010 2", letter, pattern, length);
    end
  endtask

  task automatic test_e_t;
    unit(1'b1); unit(1'b0); unit(1'b0); unit(1'b0);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd4, 4'b0000, 3'd1}) begin
      errors++;
      $display("FAIL e_letter got err=%b letter=%0d pattern=%b length=%0d want 0 4 0000 1",
               err, letter, pattern, length);
    end
    unit(1'b1); unit(1'b1); unit(1'b1); unit(1'b0); unit(1'b0); unit(1'b0);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd19, 4'b0001, 3'd1}) begin
      errors++;
      $display("FAIL t_letter got err=%b letter=%0d pattern=%b length=%0d want 0 19 0001 1",
               err, letter, pattern, length);
    end
  endtask

  task automatic test_dash_boundary;
    int v0;
    v0 = n_valid;
    unit(1'b1); unit(1'b1); unit(1'b0); unit(1'b0); unit(1'b0);
    checks++;
    if ({letter, pattern, n_valid - v0} !== {5'd19, 4'b0001, 32'd1}) begin
      errors++;
      $display("FAIL dash_min_2 got letter=%0d pattern=%b want 19 0001", letter, pattern);
    end
    send_letter(8'b0000_0100, 3);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd20, 4'b0100, 3'd3}) begin
      errors++;
      $display("FAIL u_letter got letter=%0d pattern=%b length=%0d want 20 0100 3", letter, pattern, length);
    end
  endtask

  task automatic test_saturation_q;
    repeat (20) unit(1'b1);
    repeat (3) unit(1'b0);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd19, 4'b0001, 3'd1}) begin
      errors++;
      $display("FAIL sat_dash got letter=%0d pattern=%b length=%0d want 19 0001 1", letter, pattern, length);
    end
    send_letter(8'b0000_1011, 4);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd16, 4'b1011, 3'd4}) begin
      errors++;
      $display("FAIL q_letter got err=%b letter=%0d pattern=%b length=%0d want 0 16 1011 4",
               err, letter, pattern, length);
    end
  endtask

  task automatic test_errors;
    send_letter(8'b0000_0000, 5);
    checks++;
    if ({err, letter, pattern, length} !== {1'b1, 5'd31, 4'b0000, 3'd4}) begin
      errors++;
      $display("FAIL overflow got err=%b letter=%0d pattern=%b length=%0d want 1 31 0000 4",
               err, letter, pattern, length);
    end
    send_letter(8'b0000_1100, 4);
    checks++;
    if ({err, letter, pattern, length} !== {1'b1, 5'd31, 4'b1100, 3'd4}) begin
      errors++;
      $display("FAIL undefined_pat got err=%b letter=%0d pattern=%b length=%0d want 1 31 1100 4",
               err, letter, pattern, length);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = n_valid;
    unit(1'b1); unit(1'b0); unit(1'b1); unit(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    tick  = 1'b1;
    key   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    checks++;
    if ({valid, letter, err, pattern, length, busy} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset got=%b want=0", {valid, letter, err, pattern, length, busy});
    end
    repeat (4) unit(1'b0);
    checks++;
    if (n_valid !== v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_valid pulses=%0d busy=%b want 0 0", n_valid - v0, busy);
    end
  endtask

  task automatic test_gating;
    int   v0;
    logic busy_seen;
    v0        = n_valid;
    busy_seen = 1'b0;
    tick      = 1'b0;
    repeat (20) begin
      key = ~key;
      @(negedge clk);
      busy_seen |= busy;
    end
    key = 1'b0;
    checks++;
    if (busy_seen !== 1'b0 || n_valid !== v0) begin
      errors++;
      $display("FAIL gating busy_seen=%b pulses=%0d want 0 0", busy_seen, n_valid - v0);
    end
    send_letter(8'b0000_0001, 2);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd13, 4'b0001, 3'd2}) begin
      errors++;
      $display("FAIL n_letter got letter=%0d pattern=%b length=%0d want 13 0001 2", letter, pattern, length);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_letter(8'b0000_0011, 2);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd12, 4'b0011, 3'd2}) begin
      errors++;
      $display("FAIL m_letter got letter=%0d pattern=%b length=%0d want 12 0011 2", letter, pattern, length);
    end
    send_letter(8'b0000_0101, 3);
    checks++;
    if ({err, letter, pattern, length} !== {1'b0, 5'd10, 4'b0101, 3'd3}) begin
      errors++;
      $display("FAIL k_letter got letter=%0d pattern=%b length=%0d want 10 0101 3", letter, pattern, length);
    end
    send_letter(8'b0000_0111, 4);
    checks++;
    if ({err, letter, pattern, length, n_valid - v0} !== {1'b1, 5'd31, 4'b0111, 3'd4, 32'd3}) begin
      errors++;
      $display("FAIL b2b_err got err=%b letter=%0d pattern=%b pulses=%0d want 1 31 0111 3",
               err, letter, pattern, n_valid - v0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    n_valid = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    key     = 1'b0;
    @(negedge clk);
    test_reset();
    test_a();
    test_e_t();
    test_dash_boundary();
    test_saturation_q();
    test_errors();
    test_reset_mid();
    test_gating();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Decodes a keyed Morse line (mark = 1, space = 0) back into letter codes A–Z; it is the receive end of the team's Morse transmitter.
- Time is measured in Morse units by a one-cycle `tick` strobe from the board timebase.
- Each mark is classified as a dot or a dash. Symbols are collected until an inter-letter gap, then one decoded letter is emitted with a 1-cycle `valid` pulse.

Parameters:
- DASH_MIN, 2: minimum mark length in units classified as a dash; shorter marks are dots.
- GAP_LETTER, 3: consecutive space units after a symbol that end a letter. Legal range 2..2^CNT_W-1.
- CNT_W, 4: width of the mark and gap unit counters; both saturate at all-ones.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-clk-wide unit strobe; the FSM advances only on cycles with tick=1.
- key, input, 1: keyed line, 1 = mark; already debounced and synchronous to clk; sampled only when tick=1.
- valid, output, 1: one-clk pulse; letter/err/pattern/length are valid while it is high.
- letter, output, 5: 0 = A … 25 = Z; 31 on error.
- err, output, 1: the letter just emitted was an undefined pattern or had more than 4 symbols.
- pattern, output, 4: received symbols; bit i = i-th symbol (0 = dot, 1 = dash); unused bits 0.
- length, output, 3: number of symbols, 1..4.
- busy, output, 1: high in MARK or GAP.

Behaviour:
- Reset (reset=1 at a clk edge, which beats tick): FSM to IDLE; counters, symbol buffer and overflow flag cleared; valid=0, letter=0, err=0, pattern=0, length=0, busy=0. A letter in progress is discarded and no valid is produced.
- Between ticks, all state holds. Key changes between ticks are invisible.

States:
- IDLE: on tick & key=1, go to MARK; mark_cnt=1; buffer, length and overflow cleared. On tick & key=0, stay.
- MARK, on tick & key=1: mark_cnt+1, saturating at 2^CNT_W-1.
- MARK, on tick & key=0:
  - The symbol is dash if mark_cnt>=DASH_MIN, else dot.
  - If count<4, write the symbol to buffer bit [count] and count+1; otherwise set overflow, leaving buffer and count unchanged.
  - Go to GAP with gap_cnt=1.
- GAP, on tick & key=1: go to MARK with mark_cnt=1 (intra-letter space).
- GAP, on tick & key=0: gap_cnt+1. When the new value equals GAP_LETTER, register the outputs, go to IDLE, and assert valid on the following clk cycle only.

Outputs:
- Decode uses the standard international table over (count, buffer).
- Undefined 4-symbol patterns are ..-- (pattern 1100), .-.- (1010), ---. (0111) and ---- (1111). These, or overflow, give err=1 and letter=31; pattern and length still report the stored symbols (length=4 on overflow).
- letter/err/pattern/length hold their last values after valid drops, until the next emit or reset.
- A mark that begins on the same tick as a letter emit is impossible by construction: the emit tick has key=0. The following key=1 tick starts a new letter from IDLE.

Test Plan:
- A: tick-sampled key 1,0,1,1,0,0,0 -> one valid pulse 1 clk after the 7th tick; letter=0, pattern=4'b0010, length=2, err=0; busy low after the emit.
- E and T: key 1,0,0,0 -> letter=4 (E), pattern=0, length=1. Then key 1,1,1,0,0,0 -> letter=19 (T), pattern=4'b0001, length=1.
- Saturation and Q: a 20-unit mark followed by 3 spaces -> dash, letter=19. Then --.- -> letter=16, pattern=4'b1011, length=4.
- Errors: five dots (1-unit marks, 1-unit spaces) then a letter gap -> err=1, letter=31, length=4, pattern=0. Pattern ..-- -> err=1, letter=31, pattern=4'b1100.
- Reset and gating: reset asserted mid-letter (in GAP after 2 symbols), coinciding with a tick -> no valid; all outputs 0. Key toggled on non-tick cycles only -> FSM stays in IDLE, no valid.
